time_module: RTL and testbench

//   Time-of-day counter that directly feeds the date stage's hour input.

---
 rtl/time_module.sv | 107 ++++++++++
 tb/tb_time_module.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/time_module.sv
// Time-of-day counter: prescales the system clock to a 1 Hz tick and counts hh:mm:ss in binary.
// Output packing is hhhhh_mmmmmm_ssssss; the hour field feeds the date stage directly.
module time_module #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int PRE_W    = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        time_ow,
  input  logic [16:0] time_in,
  output logic [16:0] time_out,
  output logic        sec_pulse,
  output logic        day_rollover
);

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_FREQ - 1);

  function automatic logic [5:0] clamp_min_sec(input logic [5:0] v);
    return (v > 6'd59) ? 6'd0 : v;
  endfunction

  function automatic logic [4:0] clamp_hour(input logic [4:0] v);
    return (v > 5'd23) ? 5'd0 : v;
  endfunction

  logic [PRE_W-1:0] pre_p0;
  logic             wrap_p0;
  logic             tick_p1;
  logic [4:0]       hour_p2;
  logic [5:0]       min_p2;
  logic [5:0]       sec_p2;
  logic             sec_pulse_p2;
  logic             day_roll_p2;
  logic             sec_max;
  logic             min_max;
  logic             hour_max;

  assign wrap_p0  = en && (pre_p0 == PRE_MAX);
  assign sec_max  = (sec_p2 == 6'd59);
  assign min_max  = (min_p2 == 6'd59);
  assign hour_max = (hour_p2 == 5'd23);

  // Stage 0: prescaler
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_p0 <= '0;
    end else if (time_ow || wrap_p0) begin
      pre_p0 <= '0;
    end else if (en) begin
      pre_p0 <= pre_p0 + 1'b1;
    end
  end

  // Stage 1: registered tick; held while paused so an already-counted second is not lost
  always_ff @(posedge clk) begin
    if (rst || time_ow) begin
      tick_p1 <= 1'b0;
    end else if (en) begin
      tick_p1 <= wrap_p0;
    end
  end

  // Stage 2: time fields and pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      hour_p2      <= '0;
      min_p2       <= '0;
      sec_p2       <= '0;
      sec_pulse_p2 <= 1'b0;
      day_roll_p2  <= 1'b0;
    end else if (time_ow) begin
      hour_p2      <= clamp_hour(time_in[16:12]);
      min_p2       <= clamp_min_sec(time_in[11:6]);
      sec_p2       <= clamp_min_sec(time_in[5:0]);
      sec_pulse_p2 <= 1'b0;
      day_roll_p2  <= 1'b0;
    end else begin
      sec_pulse_p2 <= 1'b0;
      day_roll_p2  <= 1'b0;
      if (en && tick_p1) begin
        sec_pulse_p2 <= 1'b1;
        if (!sec_max) begin
          sec_p2 <= sec_p2 + 1'b1;
        end else begin
          sec_p2 <= '0;
          if (!min_max) begin
            min_p2 <= min_p2 + 1'b1;
          end else begin
            min_p2 <= '0;
            if (!hour_max) begin
              hour_p2 <= hour_p2 + 1'b1;
            end else begin
              hour_p2     <= '0;
              day_roll_p2 <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign time_out     = {hour_p2, min_p2, sec_p2};
  assign sec_pulse    = sec_pulse_p2;
  assign day_rollover = day_roll_p2;

endmodule

// File: tb/tb_time_module.sv
// Bench for time_module at CLK_FREQ=4: seconds-of-day model checked every cycle plus directed literals.
module tb_time_module;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        time_ow = 1'b0;
  logic [16:0] time_in = '0;
  logic [16:0] time_out;
  logic        sec_pulse;
  logic        day_rollover;

  int n_cmp = 0;
  int n_err = 0;

  // model state: prescaler count, pending tick, seconds since midnight, expected pulses
  int m_cnt = 0;
  int m_tod = 0;
  bit m_pend = 1'b0;
  bit m_sp = 1'b0;
  bit m_dr = 1'b0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  time_module #(.CLK_FREQ(4), .PRE_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .time_ow(time_ow),
    .time_in(time_in),
    .time_out(time_out),
    .sec_pulse(sec_pulse),
    .day_rollover(day_rollover)
  );

  function automatic logic [16:0] tod_to_bits(input int t);
    return {5'(t / 3600), 6'((t / 60) % 60), 6'(t % 60)};
  endfunction

  function automatic int bits_to_tod(input logic [16:0] v);
    int h, m, s;
    h = int'(v[16:12]);
    m = int'(v[11:6]);
    s = int'(v[5:0]);
    if (h > 23) h = 0;
    if (m > 59) m = 0;
    if (s > 59) s = 0;
    return h * 3600 + m * 60 + s;
  endfunction

  task automatic cmp(input string nm, input logic [16:0] act, input logic [16:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_cnt  <= 0;
      m_pend <= 1'b0;
      m_tod  <= 0;
      m_sp   <= 1'b0;
      m_dr   <= 1'b0;
      chk_on <= 1'b1;
    end else if (time_ow) begin
      m_cnt  <= 0;
      m_pend <= 1'b0;
      m_tod  <= bits_to_tod(time_in);
      m_sp   <= 1'b0;
      m_dr   <= 1'b0;
    end else begin
      m_sp <= 1'b0;
      m_dr <= 1'b0;
      if (en) begin
        if (m_pend) begin
          m_tod <= (m_tod + 1) % 86400;
          m_sp  <= 1'b1;
          m_dr  <= (m_tod == 86399);
        end
        m_pend <= (m_cnt == 3);
        m_cnt  <= (m_cnt + 1) % 4;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("model_time_out", time_out, tod_to_bits(m_tod));
      cmp("model_sec_pulse", 17'(sec_pulse), 17'(m_sp));
      cmp("model_day_rollover", 17'(day_rollover), 17'(m_dr));
    end
  end

  task automatic wait_pulse(input string nm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sec_pulse && n < 40);
    if (!sec_pulse) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no sec_pulse in %0d cycles, required one", nm, n);
    end
  endtask

  task automatic load(input logic [16:0] v);
    time_ow = 1'b1;
    time_in = v;
    @(negedge clk);
    time_ow = 1'b0;
  endtask

  logic [16:0] ow_in  [6];
  logic [16:0] ow_exp [6];

  initial begin
    int n;
    ow_in  = '{{5'd12, 6'd34, 6'd56}, {5'd25, 6'd61, 6'd60}, {5'd25, 6'd30, 6'd45},
               {5'd12, 6'd61, 6'd56}, {5'd23, 6'd10, 6'd0},  {5'd0, 6'd0, 6'd0}};
    ow_exp = '{{5'd12, 6'd34, 6'd56}, 17'd0,                 {5'd0, 6'd30, 6'd45},
               {5'd12, 6'd0, 6'd56},  {5'd23, 6'd10, 6'd0},  17'd0};

    rst = 1'b1;
    en  = 1'b1;
    repeat (2) @(negedge clk);
    cmp("reset_time_out", time_out, 17'd0);
    cmp("reset_sec_pulse", 17'(sec_pulse), 17'd0);
    rst = 1'b0;
    wait_pulse("t1", n);
    cmp("t1_latency", 17'(n), 17'd5);
    cmp("t1_sec", time_out, 17'd1);

    load(17'h0003A);
    wait_pulse("t2a", n);
    cmp("t2_latency", 17'(n), 17'd5);
    cmp("t2_sec59", time_out, 17'h0003B);
    wait_pulse("t2b", n);
    cmp("t2_min_carry", time_out, 17'h00040);
    for (int i = 0; i < 6; i++) wait_pulse("t2c", n);
    cmp("t2_after8", time_out, 17'h00046);

    load({5'd23, 6'd59, 6'd59});
    wait_pulse("t3", n);
    cmp("t3_time", time_out, 17'd0);
    cmp("t3_rollover", 17'(day_rollover), 17'd1);
    @(negedge clk);
    cmp("t3_rollover_once", 17'(day_rollover), 17'd0);

    time_ow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      time_in = ow_in[i];
      @(negedge clk);
      cmp("t4_load", time_out, ow_exp[i]);
      cmp("t4_no_pulse", 17'({sec_pulse, day_rollover}), 17'd0);
    end
    time_ow = 1'b0;
    wait_pulse("t4", n);
    cmp("t4_latency", 17'(n), 17'd5);
    cmp("t4_count", time_out, 17'd1);

    @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    cmp("t5_frozen", time_out, 17'd1);
    en = 1'b1;
    wait_pulse("t5", n);
    cmp("t5_resume", 17'(n), 17'd3);
    cmp("t5_time", time_out, 17'd2);

    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    en = 1'b1;
    wait_pulse("t5w", n);
    cmp("t5_wrap_hold", 17'(n), 17'd2);

    repeat (2) @(negedge clk);
    load({5'd12, 6'd0, 6'd0});
    cmp("t6_load", time_out, {5'd12, 6'd0, 6'd0});
    cmp("t6_no_pulse", 17'(sec_pulse), 17'd0);
    wait_pulse("t6", n);
    cmp("t6_latency", 17'(n), 17'd5);
    cmp("t6_time", time_out, {5'd12, 6'd0, 6'd1});

    repeat (3) @(negedge clk);
    load({5'd7, 6'd7, 6'd7});
    cmp("t6_pending_discard", 17'(sec_pulse), 17'd0);
    wait_pulse("t6b", n);
    cmp("t6b_latency", 17'(n), 17'd5);

    repeat (2) @(negedge clk);
    rst = 1'b1;
    time_ow = 1'b1;
    time_in = {5'd5, 6'd5, 6'd5};
    @(negedge clk);
    cmp("t6_rst_wins", time_out, 17'd0);
    rst = 1'b0;
    time_ow = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
